// File: rtl/gpr_pkg.sv
// Shared widths, write-back request type and arbiter pointer encoding for the GPR write path.
// Pure declarations, no logic.
// Used by both the per-producer slot buffer and the write-back top.
package gpr_pkg;

    localparam int REGISTER_NUM = 32;
    localparam int ADDR_WIDTH   = 5;
    localparam int DATA_WIDTH   = 64;

    // One pending register write: destination index plus value
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    // Round-robin pointer: which producer wins when both slots hold a result
    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSU = 1'b1
    } rr_sel_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry valid/ready buffer holding a single write-back result for one producer.
// Latency: accepted result is visible on out_* the cycle after the handshake edge.
// Backpressure: ready while empty, or while full and being granted this cycle (back-to-back refill).
module wb_slot
    import gpr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  grant,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic [DATA_WIDTH-1:0] out_data
);

    wb_req_t r_req;
    logic    r_full;

    // The slot frees itself in the same cycle it drains, so a new result can land on that edge
    assign in_ready = ~r_full | grant;
    assign full     = r_full;
    assign out_rd   = r_req.rd;
    assign out_data = r_req.data;

    // Capture on handshake; otherwise empty when the arbiter takes the entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_req  <= '0;
        end else if (in_valid && in_ready) begin
            r_full     <= 1'b1;
            r_req.rd   <= in_rd;
            r_req.data <= in_data;
        end else if (grant) begin
            r_full <= 1'b0;
        end
    end

endmodule

// File: rtl/gpr_writeback.sv
// Sole writer of the GPR file: buffers ALU and LSU results, round-robin arbitrates onto one write port, tracks busy registers.
// Latency: accept at edge N -> rf_w* valid after edge N+1 (regfile writes at edge N+2) when uncontended.
// Backpressure: per-producer ready drops only while its slot is full and losing arbitration.
module gpr_writeback
    import gpr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    output logic                  rs1_busy,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs2_busy,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    logic                    w_alu_full, w_lsu_full;
    logic                    w_alu_grant, w_lsu_grant;
    logic [ADDR_WIDTH-1:0]   w_alu_rd, w_lsu_rd;
    logic [DATA_WIDTH-1:0]   w_alu_data, w_lsu_data;

    rr_sel_e                 r_rr;
    logic                    r_rf_wen;
    logic [ADDR_WIDTH-1:0]   r_rf_waddr;
    logic [DATA_WIDTH-1:0]   r_rf_wdata;
    logic [REGISTER_NUM-1:0] r_busy;

    wb_slot u_alu_slot (
        .clk      (clk),
        .rst      (rst),
        .in_valid (alu_valid),
        .in_ready (alu_ready),
        .in_rd    (alu_rd),
        .in_data  (alu_data),
        .grant    (w_alu_grant),
        .full     (w_alu_full),
        .out_rd   (w_alu_rd),
        .out_data (w_alu_data)
    );

    wb_slot u_lsu_slot (
        .clk      (clk),
        .rst      (rst),
        .in_valid (lsu_valid),
        .in_ready (lsu_ready),
        .in_rd    (lsu_rd),
        .in_data  (lsu_data),
        .grant    (w_lsu_grant),
        .full     (w_lsu_full),
        .out_rd   (w_lsu_rd),
        .out_data (w_lsu_data)
    );

    // A lone full slot always wins; with both full the pointer decides
    assign w_alu_grant = w_alu_full & (~w_lsu_full | (r_rr == RR_ALU));
    assign w_lsu_grant = w_lsu_full & (~w_alu_full | (r_rr == RR_LSU));

    // Pointer only moves on real contention, and then points at the loser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= RR_ALU;
        end else if (w_alu_full && w_lsu_full) begin
            r_rr <= (r_rr == RR_ALU) ? RR_LSU : RR_ALU;
        end
    end

    // Write port register; x0 results still consume a grant but never raise the enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_wen   <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else if (w_alu_grant) begin
            r_rf_wen   <= (w_alu_rd != '0);
            r_rf_waddr <= w_alu_rd;
            r_rf_wdata <= w_alu_data;
        end else if (w_lsu_grant) begin
            r_rf_wen   <= (w_lsu_rd != '0);
            r_rf_waddr <= w_lsu_rd;
            r_rf_wdata <= w_lsu_data;
        end else begin
            r_rf_wen   <= 1'b0;
        end
    end

    // Busy scoreboard: clear on the regfile write edge, set on issue; the later set wins a same-index race
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (r_rf_wen) begin
                r_busy[r_rf_waddr] <= 1'b0;
            end
            if (iss_valid && (iss_rd != '0)) begin
                r_busy[iss_rd] <= 1'b1;
            end
        end
    end

    assign rs1_busy = (rs1_addr != '0) & r_busy[rs1_addr];
    assign rs2_busy = (rs2_addr != '0) & r_busy[rs2_addr];

    assign rf_wen   = r_rf_wen;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed bench for gpr_writeback: reset, single write, contention, x0, set/clear race, backpressure.
// Inputs change 1 time unit after posedge; outputs sampled 1 unit later.
// Expected values are hand-derived per scenario; LSU order in the backpressure run uses a queue.
module tb_gpr_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, iss_valid;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, iss_rd, rs1_addr, rs2_addr;
    logic [63:0] alu_data, lsu_data;
    logic        rs1_busy, rs2_busy;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;

    int n_cmp = 0;
    int n_err = 0;

    gpr_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1_addr  (rs1_addr),
        .rs1_busy  (rs1_busy),
        .rs2_addr  (rs2_addr),
        .rs2_busy  (rs2_busy),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a_cnt, l_cnt, l_stall, l_writes;
        logic [63:0] lsu_q[$];
        logic [63:0] exp_d;

        rst = 1'b1;
        alu_valid = 0; lsu_valid = 0; iss_valid = 0;
        alu_rd = 0; lsu_rd = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
        alu_data = 0; lsu_data = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rs1_addr = 5'd3;
        #1;
        check_eq("rst_wen",   64'(rf_wen), 64'd0);
        check_eq("rst_waddr", 64'(rf_waddr), 64'd0);
        check_eq("rst_wdata", rf_wdata, 64'd0);
        check_eq("rst_ardy",  64'(alu_ready), 64'd1);
        check_eq("rst_lrdy",  64'(lsu_ready), 64'd1);
        check_eq("rst_busy3", 64'(rs1_busy), 64'd0);

        // ---- single write: accept at edge N, visible after N+1, busy clears at N+2
        tick();
        iss_valid = 1; iss_rd = 5'd5;
        alu_valid = 1; alu_rd = 5'd5; alu_data = 64'hDEAD;
        rs1_addr = 5'd5;
        tick();                                       // edge N
        iss_valid = 0; alu_valid = 0;
        #1;
        check_eq("sw_wen_n1",  64'(rf_wen), 64'd0);
        check_eq("sw_busy_n1", 64'(rs1_busy), 64'd1);
        tick();                                       // edge N+1
        check_eq("sw_wen_n2",   64'(rf_wen), 64'd1);
        check_eq("sw_waddr_n2", 64'(rf_waddr), 64'd5);
        check_eq("sw_wdata_n2", rf_wdata, 64'hDEAD);
        check_eq("sw_busy_n2",  64'(rs1_busy), 64'd1);
        tick();                                       // edge N+2
        check_eq("sw_wen_n3",  64'(rf_wen), 64'd0);
        check_eq("sw_busy_n3", 64'(rs1_busy), 64'd0);

        // ---- contention: ALU rd3 / LSU rd4, four results each, ALU wins first
        a_cnt = 0; l_cnt = 0;
        for (int c = 0; c < 11; c++) begin
            alu_valid = (a_cnt < 4); alu_rd = 5'd3; alu_data = 64'hA0 + 64'(a_cnt);
            lsu_valid = (l_cnt < 4); lsu_rd = 5'd4; lsu_data = 64'hB0 + 64'(l_cnt);
            #1;
            if (c <= 6) begin
                check_eq($sformatf("ct_ardy_c%0d", c), 64'(alu_ready), (c == 0) ? 64'd1 : 64'(c % 2));
                check_eq($sformatf("ct_lrdy_c%0d", c), 64'(lsu_ready), (c == 0) ? 64'd1 : 64'((c + 1) % 2));
            end
            check_eq($sformatf("ct_wen_c%0d", c), 64'(rf_wen), (c >= 2 && c <= 9) ? 64'd1 : 64'd0);
            if (c >= 2 && c <= 9) begin
                check_eq($sformatf("ct_waddr_c%0d", c), 64'(rf_waddr), (c % 2 == 0) ? 64'd3 : 64'd4);
                exp_d = ((c % 2 == 0) ? 64'hA0 : 64'hB0) + 64'((c - 2) / 2);
                check_eq($sformatf("ct_wdata_c%0d", c), rf_wdata, exp_d);
            end
            if (alu_valid && alu_ready) a_cnt++;
            if (lsu_valid && lsu_ready) l_cnt++;
            tick();
        end
        alu_valid = 0; lsu_valid = 0;

        // ---- x0: results to rd0 cycle through but never write; issue to rd0 never busy
        alu_valid = 1; alu_rd = 5'd0; alu_data = 64'hFF;
        iss_valid = 1; iss_rd = 5'd0; rs1_addr = 5'd0;
        #1 check_eq("x0_ardy0", 64'(alu_ready), 64'd1);
        tick();
        alu_data = 64'hFE; iss_valid = 0;
        #1;
        check_eq("x0_ardy1", 64'(alu_ready), 64'd1);
        check_eq("x0_busy0", 64'(rs1_busy), 64'd0);
        tick();
        alu_valid = 0;
        check_eq("x0_wen1",   64'(rf_wen), 64'd0);
        check_eq("x0_wdata1", rf_wdata, 64'hFF);
        tick();
        check_eq("x0_wen2",   64'(rf_wen), 64'd0);
        check_eq("x0_wdata2", rf_wdata, 64'hFE);
        tick();
        check_eq("x0_wen3",   64'(rf_wen), 64'd0);

        // ---- set/clear race on x7
        alu_valid = 1; alu_rd = 5'd7; alu_data = 64'h77;
        iss_valid = 1; iss_rd = 5'd7; rs2_addr = 5'd7;
        tick();
        alu_valid = 0; iss_valid = 0;
        #1 check_eq("race_busy_pre", 64'(rs2_busy), 64'd1);
        tick();
        iss_valid = 1; iss_rd = 5'd7;
        #1;
        check_eq("race_wen",   64'(rf_wen), 64'd1);
        check_eq("race_waddr", 64'(rf_waddr), 64'd7);
        tick();
        iss_valid = 0;
        #1 check_eq("race_busy_kept", 64'(rs2_busy), 64'd1);
        alu_valid = 1;
        tick();
        alu_valid = 0;
        tick();
        tick();
        check_eq("race_busy_drain", 64'(rs2_busy), 64'd0);

        // ---- backpressure: LSU stream of 6 against a competing ALU stream
        a_cnt = 0; l_cnt = 0; l_stall = 0; l_writes = 0;
        for (int c = 0; c < 40; c++) begin
            alu_valid = (a_cnt < 6); alu_rd = 5'd1; alu_data = 64'h200 + 64'(a_cnt);
            lsu_valid = (l_cnt < 6); lsu_rd = 5'd2; lsu_data = 64'h100 + 64'(l_cnt);
            #1;
            if (rf_wen && rf_waddr == 5'd2) begin
                l_writes++;
                check_eq("bp_nodup", 64'(lsu_q.size() > 0), 64'd1);
                if (lsu_q.size() > 0) check_eq("bp_data", rf_wdata, lsu_q.pop_front());
            end
            if (lsu_valid && lsu_ready) begin
                lsu_q.push_back(lsu_data);
                l_cnt++;
            end else if (lsu_valid) begin
                l_stall++;
            end
            if (alu_valid && alu_ready) a_cnt++;
            tick();
        end
        alu_valid = 0; lsu_valid = 0;
        check_eq("bp_accepted", 64'(l_cnt), 64'd6);
        check_eq("bp_written",  64'(l_writes), 64'd6);
        check_eq("bp_stalled",  64'(l_stall > 0), 64'd1);

        // ---- reset mid-operation: both slots full, x3 busy
        alu_valid = 1; alu_rd = 5'd3; alu_data = 64'h33;
        lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 64'h44;
        iss_valid = 1; iss_rd = 5'd3; rs1_addr = 5'd3;
        tick();
        iss_valid = 0;
        #1 check_eq("mr_busy_pre", 64'(rs1_busy), 64'd1);
        rst = 1'b1; alu_valid = 0; lsu_valid = 0;
        tick();
        rst = 1'b0;
        tick();
        check_eq("mr_wen",  64'(rf_wen), 64'd0);
        check_eq("mr_busy", 64'(rs1_busy), 64'd0);
        check_eq("mr_ardy", 64'(alu_ready), 64'd1);
        check_eq("mr_lrdy", 64'(lsu_ready), 64'd1);
        tick();
        check_eq("mr_wen2", 64'(rf_wen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
